// File: rtl/cpu_core_param.sv
// rtl/cpu_core_param.sv - parametrised multi-cycle CPU core with a shared wait-state memory port
module cpu_core_param #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREGS = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [4:0]        flags,
    output logic [DATA_W-1:0] alu_out,
    output logic              halted
);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    state_t state, state_next;

    logic [15:0]       ir;
    logic [ADDR_W-1:0] pc_q, ir_pc;
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] d_val, s_val;
    logic [4:0]        flags_q;
    logic [DATA_W-1:0] alu_q;

    logic [3:0] op, rd, ext, rs, alu_code;
    logic [7:0] imm8;
    logic       is_load, is_stor, is_jump, is_branch, is_halt;

    assign op   = ir[15:12];
    assign rd   = ir[11:8];
    assign ext  = ir[7:4];
    assign rs   = ir[3:0];
    assign imm8 = ir[7:0];

    assign is_load   = (op == 4'h4) && (ext == 4'h0);
    assign is_stor   = (op == 4'h4) && (ext == 4'h4);
    assign is_jump   = (op == 4'h4) && (ext == 4'hC);
    assign is_branch = (op == 4'hC);
    assign is_halt   = (op == 4'hF);
    // R-type ext codes reuse the immediate opcodes, so one ALU decode serves both
    assign alu_code  = (op == 4'h0) ? ext : op;

    // Register-sourced addresses take the low ADDR_W bits, zero-padded if DATA_W < ADDR_W
    logic [ADDR_W+DATA_W-1:0] s_ext;
    logic [ADDR_W-1:0]        s_addr;
    assign s_ext  = {{ADDR_W{1'b0}}, s_val};
    assign s_addr = s_ext[ADDR_W-1:0];

    logic unused_bits;
    assign unused_bits = ^{s_ext, mem_rdata};

    logic [DATA_W:0]   sum, diff;
    logic [DATA_W-1:0] alu_res;
    logic              carry, ovf, alu_wb, alu_flags;

    always_comb begin
        sum       = {1'b0, d_val} + {1'b0, s_val};
        diff      = {1'b0, d_val} - {1'b0, s_val};
        alu_res   = '0;
        carry     = 1'b0;
        ovf       = 1'b0;
        alu_wb    = 1'b0;
        alu_flags = 1'b0;
        case (alu_code)
            4'h5: begin
                alu_res   = sum[DATA_W-1:0];
                carry     = sum[DATA_W];
                ovf       = (d_val[MSB] == s_val[MSB]) && (alu_res[MSB] != d_val[MSB]);
                alu_wb    = 1'b1;
                alu_flags = 1'b1;
            end
            4'h9, 4'hB: begin
                alu_res   = diff[DATA_W-1:0];
                carry     = diff[DATA_W];
                ovf       = (d_val[MSB] != s_val[MSB]) && (alu_res[MSB] != d_val[MSB]);
                alu_wb    = (alu_code == 4'h9);
                alu_flags = 1'b1;
            end
            4'hD: begin alu_res = s_val;         alu_wb = 1'b1; end
            4'h1: begin alu_res = d_val & s_val; alu_wb = 1'b1; end
            4'h2: begin alu_res = d_val | s_val; alu_wb = 1'b1; end
            4'h3: begin alu_res = d_val ^ s_val; alu_wb = 1'b1; end
            default: ;
        endcase
    end

    logic cond_true;
    always_comb begin
        cond_true = 1'b0;
        case (rd)
            4'd0:  cond_true = flags_q[3];
            4'd1:  cond_true = !flags_q[3];
            4'd2:  cond_true = flags_q[0];
            4'd3:  cond_true = !flags_q[0];
            4'd4:  cond_true = flags_q[1];
            4'd5:  cond_true = !flags_q[1];
            4'd6:  cond_true = flags_q[4];
            4'd7:  cond_true = !flags_q[4];
            4'd8:  cond_true = flags_q[2];
            4'd9:  cond_true = !flags_q[2];
            4'd14: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    logic              take_pc;
    logic [ADDR_W-1:0] target;
    assign take_pc = (is_branch || is_jump) && cond_true;
    assign target  = is_jump ? s_addr : ir_pc + {{(ADDR_W-8){imm8[7]}}, imm8};

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    assign wr_en   = ((state == S_EXEC) && alu_wb) || ((state == S_MEM) && is_load && mem_ready);
    assign wr_data = (state == S_MEM) ? mem_rdata : alu_res;

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (is_load || is_stor) state_next = S_MEM;
                else if (is_halt)       state_next = S_HALT;
                else                    state_next = S_FETCH;
            end
            S_MEM:    if (mem_ready) state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            ir      <= '0;
            ir_pc   <= '0;
            d_val   <= '0;
            s_val   <= '0;
            flags_q <= '0;
            alu_q   <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            // Entries at or above NREGS are never written and so always read as zero
            for (int i = 0; i < 16; i++) begin
                if (wr_en && (i < NREGS) && (rd == 4'(i))) regs[i] <= wr_data;
            end
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir    <= mem_rdata[15:0];
                        ir_pc <= pc_q;
                        pc_q  <= pc_q + ADDR_W'(1);
                    end
                end
                S_DECODE: begin
                    d_val <= regs[rd];
                    if ((op == 4'h0) || (op == 4'h4))
                        s_val <= regs[rs];
                    else if ((op == 4'h5) || (op == 4'h9) || (op == 4'hB))
                        s_val <= {{(DATA_W-8){imm8[7]}}, imm8};
                    else
                        s_val <= {{(DATA_W-8){1'b0}}, imm8};
                end
                S_EXEC: begin
                    if (alu_flags) flags_q <= {$signed(d_val) < $signed(s_val), alu_res == '0, ovf, d_val < s_val, carry};
                    if (alu_wb || alu_flags) alu_q <= alu_res;
                    if (take_pc) pc_q <= target;
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = reset && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we    = reset && (state == S_MEM) && is_stor;
    assign mem_addr  = (state == S_MEM) ? s_addr : pc_q;
    assign mem_wdata = d_val;
    assign pc        = pc_q;
    assign flags     = flags_q;
    assign alu_out   = alu_q;
    assign halted    = reset && (state == S_HALT);
endmodule
